// File: rtl/uart_receiver.sv
// 8N1 UART receiver: double-flop synchronised line, mid-bit sampling, and
// one-cycle data_valid / framing_error strobes; a low stop bit parks in BREAK.
module uart_receiver #(
  parameter int CLKS_PER_BIT  = 462,
  parameter int COUNTER_WIDTH = 9
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       uart_rx,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       framing_error,
  output logic       rx_running
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam logic [COUNTER_WIDTH-1:0] HALF_LAST  = COUNTER_WIDTH'(HALF - 1);
  localparam logic [COUNTER_WIDTH-1:0] BIT_LAST   = COUNTER_WIDTH'(CLKS_PER_BIT - 1);
  localparam logic [COUNTER_WIDTH-1:0] COUNT_ZERO = COUNTER_WIDTH'(0);
  localparam logic [COUNTER_WIDTH-1:0] COUNT_ONE  = COUNTER_WIDTH'(1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  logic                     sync1_reg;
  logic                     rx_s;
  state_t                   state_reg, state_next;
  logic [COUNTER_WIDTH-1:0] count_reg, count_next;
  logic [2:0]               bit_index_reg, bit_index_next;
  logic [7:0]               shift_reg, shift_next;
  logic [7:0]               data_reg, data_next;
  logic                     data_valid_reg, data_valid_next;
  logic                     framing_error_reg, framing_error_next;
  logic                     rx_running_reg;

  // Both synchroniser flops reset high so a reset never looks like a start bit.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      sync1_reg <= 1'b1;
      rx_s      <= 1'b1;
    end else begin
      sync1_reg <= uart_rx;
      rx_s      <= sync1_reg;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_reg         <= IDLE;
      count_reg         <= COUNT_ZERO;
      bit_index_reg     <= 3'd0;
      shift_reg         <= 8'h00;
      data_reg          <= 8'h00;
      data_valid_reg    <= 1'b0;
      framing_error_reg <= 1'b0;
      rx_running_reg    <= 1'b0;
    end else begin
      state_reg         <= state_next;
      count_reg         <= count_next;
      bit_index_reg     <= bit_index_next;
      shift_reg         <= shift_next;
      data_reg          <= data_next;
      data_valid_reg    <= data_valid_next;
      framing_error_reg <= framing_error_next;
      rx_running_reg    <= (state_next != IDLE);
    end
  end

  always_comb begin
    state_next         = state_reg;
    count_next         = count_reg;
    bit_index_next     = bit_index_reg;
    shift_next         = shift_reg;
    data_next          = data_reg;
    data_valid_next    = 1'b0;
    framing_error_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!rx_s) begin
          state_next = START;
          count_next = COUNT_ZERO;
        end
      end
      START: begin
        // Re-check the line half a bit in; a high level here was only a glitch.
        if (count_reg == HALF_LAST) begin
          count_next = COUNT_ZERO;
          if (!rx_s) begin
            state_next     = DATA;
            bit_index_next = 3'd0;
          end else begin
            state_next = IDLE;
          end
        end else begin
          count_next = count_reg + COUNT_ONE;
        end
      end
      DATA: begin
        if (count_reg == BIT_LAST) begin
          count_next = COUNT_ZERO;
          shift_next = {rx_s, shift_reg[7:1]};
          if (bit_index_reg == 3'd7) begin
            state_next = STOP;
          end else begin
            bit_index_next = bit_index_reg + 3'd1;
          end
        end else begin
          count_next = count_reg + COUNT_ONE;
        end
      end
      STOP: begin
        if (count_reg == BIT_LAST) begin
          count_next = COUNT_ZERO;
          if (rx_s) begin
            data_next       = shift_reg;
            data_valid_next = 1'b1;
            state_next      = IDLE;
          end else begin
            framing_error_next = 1'b1;
            state_next         = BREAK;
          end
        end else begin
          count_next = count_reg + COUNT_ONE;
        end
      end
      BREAK: begin
        if (rx_s) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign data          = data_reg;
  assign data_valid    = data_valid_reg;
  assign framing_error = framing_error_reg;
  assign rx_running    = rx_running_reg;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed and randomised frames against a timing/data model derived from
// the receiver's sampling rules (CLKS_PER_BIT = 8).
module tb_uart_receiver;

  localparam int CPB  = 8;
  localparam int HALF = CPB / 2;
  // Line change at a negedge -> 2 synchroniser edges -> t0 one edge later,
  // stop sample at t0+HALF+9*CPB, strobe visible at the following negedge.
  localparam int LAT  = 3 + HALF + 9 * CPB;

  logic       clk_in  = 1'b0;
  logic       reset   = 1'b1;
  logic       uart_rx = 1'b1;
  logic [7:0] data;
  logic       data_valid;
  logic       framing_error;
  logic       rx_running;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int         dv_cyc_q[$];
  logic [7:0] dv_data_q[$];
  int         fe_cyc_q[$];
  logic       run_hist [0:8191];

  uart_receiver #(
    .CLKS_PER_BIT (CPB),
    .COUNTER_WIDTH(4)
  ) dut (
    .clk_in       (clk_in),
    .reset        (reset),
    .uart_rx      (uart_rx),
    .data         (data),
    .data_valid   (data_valid),
    .framing_error(framing_error),
    .rx_running   (rx_running)
  );

  initial forever #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $fatal(1, "FAIL watchdog: simulation did not finish in time");
  end

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk_in) begin
    if (cyc < 8192) run_hist[cyc] <= rx_running;
    if (data_valid) begin
      dv_cyc_q.push_back(cyc);
      dv_data_q.push_back(data);
    end
    if (framing_error) fe_cyc_q.push_back(cyc);
    if (data_valid || framing_error)
      check("dv_fe_exclusive", 32'(data_valid & framing_error), 32'd0);
  end

  task automatic idle(input int n);
    uart_rx = 1'b1;
    repeat (n) @(negedge clk_in);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, output int start);
    start   = cyc;
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk_in);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk_in);
    end
    uart_rx = stop;
    repeat (CPB) @(negedge clk_in);
  endtask

  task automatic expect_dv(input string tag, input int exp_cyc, input logic [7:0] exp_data);
    check({tag, "_dv_present"}, 32'(dv_cyc_q.size() != 0), 32'd1);
    if (dv_cyc_q.size() != 0) begin
      check({tag, "_dv_cycle"}, dv_cyc_q.pop_front(), exp_cyc);
      check({tag, "_dv_data"}, 32'(dv_data_q.pop_front()), 32'(exp_data));
    end
  endtask

  task automatic check_outputs_clear(input string tag);
    check({tag, "_data"}, 32'(data), 32'h00);
    check({tag, "_dv"}, 32'(data_valid), 32'd0);
    check({tag, "_fe"}, 32'(framing_error), 32'd0);
    check({tag, "_running"}, 32'(rx_running), 32'd0);
  endtask

  // rx_running must be high on every cycle in [from, to) and low at 'to'.
  task automatic check_running(input string tag, input int from, input int to);
    logic all_high;
    all_high = 1'b1;
    for (int i = from; i < to; i++)
      if (run_hist[i] !== 1'b1) all_high = 1'b0;
    check({tag, "_running_high"}, 32'(all_high), 32'd1);
    check({tag, "_running_low_after"}, 32'(run_hist[to]), 32'd0);
  endtask

  initial begin
    int         c0, c1, gap;
    logic [7:0] b;
    logic [7:0] model_data;
    int         exp_cyc_q[$];
    logic [7:0] exp_byte_q[$];

    model_data = 8'h00;
    repeat (3) @(negedge clk_in);
    check_outputs_clear("reset");
    reset = 1'b0;
    idle(10);

    // Ideal frame 0x55
    send_frame(8'h55, 1'b1, c0);
    idle(10);
    model_data = 8'h55;
    expect_dv("f55", c0 + LAT, model_data);
    check("f55_no_fe", 32'(fe_cyc_q.size()), 32'd0);
    check("f55_idle_before_t0", 32'(run_hist[c0 + 2]), 32'd0);
    check_running("f55", c0 + 3, c0 + LAT);

    // Back-to-back frames, single stop bit
    send_frame(8'hA3, 1'b1, c0);
    send_frame(8'h0F, 1'b1, c1);
    idle(10);
    expect_dv("b2b_a3", c0 + LAT, 8'hA3);
    expect_dv("b2b_0f", c1 + LAT, 8'h0F);
    model_data = 8'h0F;

    // Two-cycle glitch: START entered, abandoned at t0+HALF
    c0 = cyc;
    uart_rx = 1'b0;
    repeat (2) @(negedge clk_in);
    idle(20);
    check("glitch_no_dv", 32'(dv_cyc_q.size()), 32'd0);
    check("glitch_no_fe", 32'(fe_cyc_q.size()), 32'd0);
    check("glitch_data_held", 32'(data), 32'(model_data));
    check_running("glitch", c0 + 3, c0 + 3 + HALF);

    // Low stop bit followed by a long break
    send_frame(8'h3C, 1'b0, c0);
    repeat (40) @(negedge clk_in);
    c1 = cyc;
    idle(10);
    check("break_fe_count", 32'(fe_cyc_q.size()), 32'd1);
    if (fe_cyc_q.size() != 0) check("break_fe_cycle", fe_cyc_q.pop_front(), c0 + LAT);
    check("break_no_dv", 32'(dv_cyc_q.size()), 32'd0);
    check("break_data_held", 32'(data), 32'(model_data));
    check_running("break", c0 + 3, c1 + 3);

    // Reset pulse in the middle of data bit 3 of 0xFF
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk_in);
    uart_rx = 1'b1;
    repeat (3 * CPB + CPB / 4) @(negedge clk_in);
    reset = 1'b1;
    @(negedge clk_in);
    reset = 1'b0;
    model_data = 8'h00;
    check_outputs_clear("midreset");
    idle(11 * CPB);
    check("midreset_no_dv", 32'(dv_cyc_q.size()), 32'd0);
    check("midreset_no_fe", 32'(fe_cyc_q.size()), 32'd0);
    send_frame(8'h81, 1'b1, c0);
    idle(10);
    model_data = 8'h81;
    expect_dv("after_reset", c0 + LAT, model_data);

    // Reset while the line is low: the low line is a fresh start afterwards
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk_in);
    reset = 1'b1;
    @(negedge clk_in);
    reset = 1'b0;
    send_frame(8'h96, 1'b1, c0);
    idle(10);
    model_data = 8'h96;
    expect_dv("low_reset", c0 + LAT, model_data);

    // Random bytes with random idle gaps (including zero)
    for (int k = 0; k < 6; k++) begin
      b   = 8'($urandom);
      gap = int'($urandom_range(0, 4));
      idle(gap);
      send_frame(b, 1'b1, c0);
      exp_cyc_q.push_back(c0 + LAT);
      exp_byte_q.push_back(b);
    end
    idle(10);
    for (int k = 0; k < 6; k++) begin
      model_data = exp_byte_q[k];
      expect_dv("rand", exp_cyc_q[k], model_data);
    end
    check("rand_data_held", 32'(data), 32'(model_data));
    check("final_no_extra_dv", 32'(dv_cyc_q.size()), 32'd0);
    check("final_no_extra_fe", 32'(fe_cyc_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
